// File: rtl/datapath_pkg.sv
// Shared types for the parametrised datapath: operation select codes and FSM states.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package datapath_pkg;

    // Encodings match the external sel field directly.
    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_SHL = 2'b10,
        OP_MUL = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/datapath_mul_iter.sv
// Iterative unsigned shift-add multiplier, one multiplier bit per cycle, LSB first.
// Latency: CW cycles after load; prod is the final product combinationally during the last busy cycle.
// Backpressure: none; load restarts unconditionally, rst aborts and clears.
// Ports: clk/rst, load with mcand/mplier operands, busy while iterating,
// fin on the last iteration, prod = accumulator plus current partial product.
module datapath_mul_iter #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic [W/2-1:0] mcand,
    input  logic [W/2-1:0] mplier,
    output logic           busy,
    output logic           fin,
    output logic [W-1:0]   prod
);
    localparam int CW = W / 2;
    localparam logic [CW-1:0] CNT_LAST = CW'(CW - 1);

    logic [W-1:0]  mcand_q;
    logic [W-1:0]  acc_q;
    logic [W-1:0]  pp;
    logic [CW-1:0] mplier_q;
    logic [CW-1:0] cnt_q;
    logic          busy_q;

    assign pp   = mplier_q[0] ? mcand_q : '0;
    // Exposing acc+pp lets the caller capture the product on the same edge
    // that retires the last multiplier bit, saving a cycle.
    assign prod = acc_q + pp;
    assign fin  = (cnt_q == CNT_LAST);
    assign busy = busy_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else if (load) begin
            mcand_q  <= {{CW{1'b0}}, mcand};
            mplier_q <= mplier;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
        end else if (busy_q) begin
            acc_q    <= prod;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            if (fin) begin
                busy_q <= 1'b0;
                cnt_q  <= '0;
            end else begin
                cnt_q  <= cnt_q + CW'(1);
            end
        end
    end

endmodule

// File: rtl/param_datapath.sv
// Multi-cycle datapath: add/sub/shift-left in one execute cycle, multiply over W/2 cycles.
// Latency: done 1 cycle after accept for ALU ops, CW cycles for multiply; one-cycle done pulse.
// Backpressure: ready high only in IDLE; start while not ready is dropped, never queued.
// Ports: clk, rst (sync, active-high), start/sel/a/b/c/d request, ready, done, result, ovf.
// Build option PARAM_DATAPATH_SAT_EN: saturate add/shift to all ones and sub to zero on ovf.
module param_datapath
    import datapath_pkg::*;
#(
    parameter  int W  = 8,
    localparam int CW = W / 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [1:0]    sel,
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    input  logic [CW-1:0] c,
    input  logic [CW-1:0] d,
    output logic          ready,
    output logic          done,
    output logic [W-1:0]  result,
    output logic          ovf
);
    state_e        state_q, state_d;
    op_e           op_q;
    logic [W-1:0]  a_q, b_q;
    logic [CW-1:0] d_q;
    logic          accept;
    logic          exec_fin;
    logic          mul_busy, mul_fin;
    logic [W-1:0]  mul_prod;
    logic [W-1:0]  alu_res;
    logic          alu_ovf;
    logic [W:0]    sum_w;
    logic [2*W-1:0] shl_w;
    logic [31:0]   shamt;

    assign accept = start && (state_q == ST_IDLE);

    datapath_mul_iter #(.W(W)) u_mul (
        .clk    (clk),
        .rst    (rst),
        .load   (accept && (sel == OP_MUL)),
        .mcand  (c),
        .mplier (d),
        .busy   (mul_busy),
        .fin    (mul_fin),
        .prod   (mul_prod)
    );

    // Operands are captured on acceptance so later input changes cannot
    // disturb an in-flight operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q <= OP_ADD;
            a_q  <= '0;
            b_q  <= '0;
            d_q  <= '0;
        end else if (accept) begin
            op_q <= op_e'(sel);
            a_q  <= a;
            b_q  <= b;
            d_q  <= d;
        end
    end

    always_comb begin
        sum_w   = {1'b0, a_q} + {1'b0, b_q};
        shamt   = 32'(d_q) % 32'(W);
        // Double-width shift: the upper half holds whatever fell off the top.
        shl_w   = {{W{1'b0}}, a_q} << shamt;
        alu_res = '0;
        alu_ovf = 1'b0;
        case (op_q)
            OP_ADD: begin
                alu_res = sum_w[W-1:0];
                alu_ovf = sum_w[W];
            end
            OP_SUB: begin
                alu_res = a_q - b_q;
                alu_ovf = (a_q < b_q);
            end
            OP_SHL: begin
                alu_res = shl_w[W-1:0];
                alu_ovf = |shl_w[2*W-1:W];
            end
            default: begin
                alu_res = mul_prod;
                alu_ovf = 1'b0;
            end
        endcase
`ifdef PARAM_DATAPATH_SAT_EN
        if (alu_ovf) begin
            alu_res = (op_q == OP_SUB) ? '0 : '1;
        end
`endif
    end

    assign exec_fin = (state_q == ST_EXEC) &&
                      ((op_q != OP_MUL) || (mul_busy && mul_fin));

    always_ff @(posedge clk) begin
        if (rst) begin
            result <= '0;
            ovf    <= 1'b0;
        end else if (exec_fin) begin
            result <= alu_res;
            ovf    <= alu_ovf;
        end
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start)    state_d = ST_EXEC;
            ST_EXEC: if (exec_fin) state_d = ST_DONE;
            ST_DONE:               state_d = ST_IDLE;
            default:               state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        ready = (state_q == ST_IDLE);
        done  = (state_q == ST_DONE);
    end

endmodule

// File: tb/tb_param_datapath.sv
// Directed bench for param_datapath (W=8) with an expected-result queue.
// Latency: n/a.
// Backpressure: n/a.
module tb_param_datapath;
    localparam int W  = 8;
    localparam int CW = W / 2;

    typedef struct {
        logic [W-1:0] res;
        logic         ovf;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    sel = '0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic [CW-1:0] c = '0;
    logic [CW-1:0] d = '0;
    logic          ready;
    logic          done;
    logic [W-1:0]  result;
    logic          ovf;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];

    param_datapath #(.W(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .sel    (sel),
        .a      (a),
        .b      (b),
        .c      (c),
        .d      (d),
        .ready  (ready),
        .done   (done),
        .result (result),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Independent reference for the four operations.
    function automatic exp_t model(input logic [1:0] s, input logic [W-1:0] ia,
                                   input logic [W-1:0] ib, input logic [CW-1:0] ic,
                                   input logic [CW-1:0] id);
        exp_t e;
        int   x;
        int   sh;
        e.res = '0;
        e.ovf = 1'b0;
        case (s)
            2'b00: begin x = int'(ia) + int'(ib); e.res = W'(x); e.ovf = (x > 255); end
            2'b01: begin e.res = W'(int'(ia) - int'(ib)); e.ovf = (ia < ib); end
            2'b10: begin
                sh = int'(id) % W;
                x  = int'(ia) * (1 << sh);
                e.res = W'(x);
                e.ovf = (x > 255);
            end
            default: begin e.res = W'(int'(ic) * int'(id)); e.ovf = 1'b0; end
        endcase
`ifdef PARAM_DATAPATH_SAT_EN
        if (e.ovf) e.res = (s == 2'b01) ? 8'h00 : 8'hFF;
`endif
        return e;
    endfunction

    // Drive a one-cycle start; returns just after the accepting edge, with
    // operands scrambled to show they were latched.
    task automatic issue(input logic [1:0] s, input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic [CW-1:0] ic, input logic [CW-1:0] id);
        sel = s; a = ia; b = ib; c = ic; d = id;
        start = 1'b1;
        sb.push_back(model(s, ia, ib, ic, id));
        tick();
        start = 1'b0;
        a = ~ia; b = ~ib; c = ~ic; d = ~id; sel = ~s;
    endtask

    // Wait (bounded) for done, check latency, result, pulse width, ready return.
    task automatic wait_done(input string tag, input int exp_lat, input int n0);
        exp_t e;
        int   n;
        n = n0;
        while (done !== 1'b1 && n < 20) begin
            chk({tag, "_ready_low"}, 32'(ready), 32'd0);
            tick();
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'(exp_lat));
        e = sb.pop_front();
        chk({tag, "_result"}, 32'(result), 32'(e.res));
        chk({tag, "_ovf"}, 32'(ovf), 32'(e.ovf));
        tick();
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        chk({tag, "_ready_back"}, 32'(ready), 32'd1);
    endtask

    initial begin
        int dones;
        exp_t dummy;

        // Reset
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);

        // Multiply by zero multiplicand
        issue(2'b11, 8'h00, 8'hFF, 4'h0, 4'hA);
        wait_done("mul_zero", 4, 0);

        // Add with carry out
        issue(2'b00, 8'hC8, 8'h64, 4'h0, 4'h0);
        chk("add_exp_const", 32'(sb[0].res),
`ifdef PARAM_DATAPATH_SAT_EN
            32'hFF
`else
            32'h2C
`endif
        );
        wait_done("add_carry", 1, 0);

        // Subtract with and without borrow
        issue(2'b01, 8'h10, 8'h20, 4'h0, 4'h0);
        wait_done("sub_borrow", 1, 0);
        issue(2'b01, 8'h20, 8'h10, 4'h0, 4'h0);
        wait_done("sub_plain", 1, 0);

        // Shift: bit lost off the top, then amount taken modulo W
        issue(2'b10, 8'h81, 8'h00, 4'h0, 4'h1);
        wait_done("shl_ovf", 1, 0);
        issue(2'b10, 8'h01, 8'h00, 4'h0, 4'h9);
        wait_done("shl_mod", 1, 0);

        // Multiply F*F with an ignored start pulse during EXEC
        issue(2'b11, 8'h00, 8'h00, 4'hF, 4'hF);
        sel = 2'b00; a = 8'h01; b = 8'h01; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("mul_ff", 4, 1);
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            if (done === 1'b1) dones++;
            tick();
        end
        chk("mul_ff_no_extra_done", 32'(dones), 32'd0);
        chk("mul_ff_result_hold", 32'(result), 32'hE1);

        // Reset on the second EXEC cycle of a multiply
        issue(2'b11, 8'h00, 8'h00, 4'hF, 4'hF);
        dummy = sb.pop_back();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_ready", 32'(ready), 32'd1);
        chk("abort_result", 32'(result), 32'd0);
        chk("abort_ovf", 32'(ovf), 32'd0);
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            if (done === 1'b1) dones++;
            tick();
        end
        chk("abort_no_done", 32'(dones), 32'd0);
        issue(2'b00, 8'h01, 8'h02, 4'h0, 4'h0);
        wait_done("after_abort", 1, 0);

        // start held high through DONE: accepted again in the next IDLE cycle
        sel = 2'b00; a = 8'h03; b = 8'h04; c = '0; d = '0;
        start = 1'b1;
        sb.push_back(model(2'b00, 8'h03, 8'h04, 4'h0, 4'h0));
        sb.push_back(model(2'b00, 8'h03, 8'h04, 4'h0, 4'h0));
        tick();
        wait_done("held_first", 1, 0);
        tick();
        start = 1'b0;
        wait_done("held_second", 1, 0);

        // A few random ALU and multiply operations
        for (int i = 0; i < 8; i++) begin
            logic [1:0]    rs;
            logic [W-1:0]  ra, rb;
            logic [CW-1:0] rc, rd;
            rs = 2'($urandom_range(0, 3));
            ra = W'($urandom); rb = W'($urandom);
            rc = CW'($urandom); rd = CW'($urandom);
            issue(rs, ra, rb, rc, rd);
            wait_done("rand", (rs == 2'b11) ? CW : 1, 0);
        end

        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/param_datapath.md
# param_datapath

Parametrised multi-cycle datapath with a start/ready handshake. It is the next generation of the lab datapath block. It accepts two W-bit operands and two W/2-bit operands, and performs one of four operations chosen by `sel`. Add, subtract and shift complete in a single execute cycle. Multiply is an iterative shift-add over W/2 cycles. Each result is reported with an overflow flag and a one-cycle `done` pulse.

## Interface
- `W`, default 8: width of operands `a`, `b` and of `result`. Must be even and at least 4.
- Derived localparam `CW` = W/2: width of `c` and `d`.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  request; sampled only while `ready`=1.
- `sel`  in  2  operation: 00 add, 01 sub, 10 shift-left, 11 multiply.
- `a`  in  W  operand.
- `b`  in  W  operand.
- `c`  in  CW  multiplicand.
- `d`  in  CW  multiplier; the low log2(W) bits also give the shift amount.
- `ready`  out  1  high in IDLE only.
- `done`  out  1  one-cycle pulse; `result` and `ovf` are valid.
- `result`  out  W  registered result; holds until the next accepted operation completes.
- `ovf`  out  1  overflow flag for the last result.

## Operation
- FSM states: IDLE, EXEC, DONE.
- Transitions:
  - IDLE→EXEC on `start`&`ready`. All inputs are latched on that edge; later input changes are ignored.
  - EXEC→DONE after 1 cycle for sel 00/01/10.
  - EXEC→DONE after CW cycles for sel 11.
  - DONE→IDLE unconditionally.
- Add: result = (a+b) mod 2^W; ovf = carry out.
- Sub: result = (a−b) mod 2^W; ovf = borrow (a<b, unsigned).
- Shift: result = a << (d mod W), zero fill; ovf = 1 if any 1-bit was shifted out.
- Multiply:
  - Unsigned c×d, 2·CW = W bits, so it always fits; ovf = 0.
  - An internal CW-bit counter steps one multiplier bit per EXEC cycle (LSB first).
  - The partial product is added into a W-bit accumulator each cycle.
- `start` while `ready`=0 is ignored. It is neither queued nor able to corrupt the in-flight operation.
- `start` held high through DONE is accepted again in the following IDLE cycle.

## Timing
- Reset values: `ready`=1, `done`=0, `result`=0, `ovf`=0, FSM=IDLE, counter=0, accumulator=0.
- Edge E0 accepts `start`; `ready` falls in the cycle after E0.
- Add/sub/shift: `result`/`ovf` are written at E1. `done`=1 between E1 and E2. `ready`=1 again after E2.
- Multiply: `result` is written at E_CW. `done`=1 between E_CW and E_CW+1. W=8 gives done 4 cycles after acceptance.
- Throughput: one operation per 3 cycles (ALU ops) or CW+2 cycles (multiply).
- `rst` asserted in any state, including mid-multiply, returns all outputs to reset values at the next edge. The partial result is discarded and no `done` is issued.
- `rst` has priority over `start` on the same edge.

## Configuration
- Macro `PARAM_DATAPATH_SAT_EN`.
- Defined: add and shift saturate to all ones when ovf=1; sub saturates to 0 when ovf=1. `ovf` still reports the event.
- Undefined: wrap-around results as specified above. Latency is identical in both builds.

## Structure
- Package `datapath_pkg` holds:
  - the op enum (OP_ADD, OP_SUB, OP_SHL, OP_MUL) matching the `sel` encodings;
  - the FSM state enum.
- One sub-module, `datapath_mul_iter`, holds the shift-add multiplier: counter, accumulator, and a `busy`/`fin` interface to the top FSM.
- The top level owns the FSM, input latches, ALU ops, `ovf` and the saturation logic.

## Test plan (W=8)
- Reset, then sel=11, a=00, b=FF, c=0, d=A, one-cycle `start` → result=00, ovf=0, `done` 4 cycles after acceptance, `ready` low throughout.
- sel=00, a=C8, b=64 → result=2C, ovf=1 (SAT build: FF); `done` at E1+.
- sel=01, a=10, b=20 → result=F0, ovf=1 (SAT build: 00). Then sel=01, a=20, b=10 → result=10, ovf=0.
- sel=10, a=81, d=1 → result=02, ovf=1 (SAT build: FF). Then sel=10, a=01, d=9 (shift 1) → result=02, ovf=0.
- sel=11, c=F, d=F; pulse `start` with sel=00 during EXEC → the second request is ignored; result=E1, ovf=0 after 4 cycles.
- sel=11, c=F, d=F; assert `rst` on the 2nd EXEC cycle → next cycle `ready`=1, `result`=0, `done` never pulses; a new op then completes normally.
